lisa_qspi_burst_sequencer: RTL and testbench
============================================

# lisa_qspi_burst_sequencer

Client-side sequencer that sits between a LISA-side bulk-transfer requester and one client port of the QSPI arbiter. It splits a host request of up to 65535 16-bit words into QSPI bursts of at most MAX_BURST words, and never lets a burst cross a PAGE_BYTES flash page boundary. It runs the per-word ready / ready_ack handshake and streams data through valid/ready interfaces.

## Interface
- CHIP_SELECTS, 2, width of ce_ctrl
- MAX_BURST, 8, max words per QSPI request; 1..15
- PAGE_BYTES, 256, page size in bytes; power of 2, ≥ 2*MAX_BURST
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request strobe, sampled only in IDLE
- write  in  1  1 = write, 0 = read; latched on start
- base_addr  in  24  byte address; bit0 forced to 0
- word_count  in  16  number of 16-bit words
- ce_sel  in  CHIP_SELECTS  chip-select pattern; latched on start
- abort  in  1  stop after the current burst
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- aborted  out  1  valid with done; 1 = request was cut short
- s_wdata  in  16 / s_wvalid  in  1 / s_wready  out  1  write-data stream
- m_rdata  out  16 / m_rvalid  out  1 / m_rready  in  1  read-data stream, one-entry output register
- q_addr  out  24 / q_wdata  out  16 / q_wstrb  out  2 / q_valid  out  1 / q_xfer_len  out  4 / q_ce_ctrl  out  CHIP_SELECTS / q_ready_ack  out  1  arbiter client outputs
- q_rdata  in  16 / q_ready  in  1 / q_xfer_done  in  1  arbiter client inputs

## Operation
- States: IDLE, CALC, ISSUE, ACK, FIN.
- IDLE
  - start with word_count == 0: done = 1 the next cycle with aborted = 0; stay in IDLE.
  - Otherwise latch the request: addr = base_addr & ~1, remaining = word_count. Go to CALC.
- CALC (1 cycle)
  - Page room: room = (PAGE_BYTES - addr[log2(PAGE_BYTES)-1:0]) >> 1.
  - burst = min(remaining, MAX_BURST, room), 16-bit unsigned compare. Clear wcnt. Go to ISSUE.
- ISSUE
  - q_valid = 1 and stays high until q_xfer_done.
  - For a write, q_valid first rises only when s_wvalid = 1.
  - Accept condition: q_ready = 1 and wcnt < burst and (write ? s_wvalid : (!m_rvalid | m_rready)).
  - On accept, register q_ready_ack = 1 for one cycle.
    - Write: s_wready pulses for the same cycle.
    - Read: q_rdata is captured into m_rdata and m_rvalid is set.
  - wcnt increments on accept. Go to ACK.
  - On q_xfer_done: addr += 2*burst (24-bit wrap), remaining -= burst. Go to FIN.
- ACK (1 cycle)
  - q_ready is ignored because the controller is dropping it. Return to ISSUE.
- FIN
  - If remaining == 0 or an abort is pending: done = 1, aborted = the pending abort flag. Go to IDLE.
  - Otherwise go to CALC.
- Outputs held from the request:
  - q_addr = addr, q_xfer_len = burst, q_ce_ctrl = latched ce_sel.
  - q_wstrb = 2'b11 for writes, 2'b00 for reads.
  - q_wdata = s_wdata.
- Abort
  - Abort in CALC, or in ISSUE before q_valid has risen: go straight to FIN with aborted = 1.
  - Abort at any later point sets a pending flag. The current burst finishes normally, including all of its data beats.
- m_rvalid clears when m_rready = 1. Read data is never overwritten or dropped.

## Timing
- Reset (async): state IDLE; all outputs 0, including busy, done, aborted, q_valid, q_ready_ack, s_wready, m_rvalid, q_addr, q_ce_ctrl, q_xfer_len, m_rdata.
- start sampled at edge N: busy = 1 after N+1. CALC runs for one cycle, then q_valid = 1 after N+2; for a write, this is the first cycle s_wvalid is also high.
- q_ready high at edge M with accept true: q_ready_ack is high for exactly one cycle, from M+1 to M+2. The earliest next accept is M+2.
- A read beat is presented on m_rvalid in the same cycle as its q_ready_ack.
- q_xfer_done sampled at edge K: q_valid = 0 after K+1. The next burst's q_valid follows at K+3 (FIN, then CALC).
- Last burst: done is high in the cycle after FIN is entered. busy drops in the same cycle that done is high.
- start, abort and q_ready are all ignored while in IDLE, except start as defined above.

## Test plan
- Read of 5 words at 0x000010 → one burst with q_addr = 0x000010, q_xfer_len = 5, 5 acks, 5 m_rvalid beats carrying q_rdata in order; done after q_xfer_done; aborted = 0.
- Read of 20 words at 0x000000 → bursts (0x000000, 8), (0x000010, 8), (0x000020, 4); exactly one done.
- Write of 6 words at 0x0000FA with PAGE_BYTES = 256 → bursts (0x0000FA, 3) and (0x000100, 3); q_wstrb = 2'b11; s_wready count = 6.
- Write with s_wvalid low for 10 cycles after start → q_valid stays 0. Then a mid-burst s_wvalid gap with q_ready high → q_ready_ack withheld until s_wvalid = 1.
- Read with m_rready held low for 20 cycles → no second ack while m_rvalid = 1; all data arrives intact.
- Abort during the second burst of a 20-word read → that burst completes, no third burst, done with aborted = 1. word_count = 0 → done next cycle with no q_valid. rst mid-burst → all outputs 0 immediately, then a fresh 4-word read works.

Source files
------------

// File: rtl/lisa_qspi_burst_sequencer.sv
// rtl/lisa_qspi_burst_sequencer.sv - splits bulk word transfers into page-safe QSPI bursts
// One request in flight; each burst runs the arbiter's per-word ready/ready_ack handshake.
module lisa_qspi_burst_sequencer #(
   parameter int CHIP_SELECTS = 2,
   parameter int MAX_BURST    = 8,
   parameter int PAGE_BYTES   = 256
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic                    write_i,
   input  logic [23:0]             base_addr_i,
   input  logic [15:0]             word_count_i,
   input  logic [CHIP_SELECTS-1:0] ce_sel_i,
   input  logic                    abort_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    aborted_o,
   input  logic [15:0]             s_wdata_i,
   input  logic                    s_wvalid_i,
   output logic                    s_wready_o,
   output logic [15:0]             m_rdata_o,
   output logic                    m_rvalid_o,
   input  logic                    m_rready_i,
   output logic [23:0]             q_addr_o,
   output logic [15:0]             q_wdata_o,
   output logic [1:0]              q_wstrb_o,
   output logic                    q_valid_o,
   output logic [3:0]              q_xfer_len_o,
   output logic [CHIP_SELECTS-1:0] q_ce_ctrl_o,
   output logic                    q_ready_ack_o,
   input  logic [15:0]             q_rdata_i,
   input  logic                    q_ready_i,
   input  logic                    q_xfer_done_i
);

   localparam int PAGE_W = $clog2(PAGE_BYTES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE,
      S_ACK,
      S_FIN
   } state_e;

   state_e                  state_q;
   logic [23:0]             addr_q;
   logic [15:0]             remaining_q;
   logic [3:0]              burst_q;
   logic [3:0]              wcnt_q;
   logic                    write_q;
   logic [CHIP_SELECTS-1:0] ce_q;
   logic                    abort_pend_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    aborted_q;
   logic                    q_valid_q;
   logic                    q_ready_ack_q;
   logic                    s_wready_q;
   logic                    m_rvalid_q;
   logic [15:0]             m_rdata_q;

   logic [PAGE_W:0]         room_bytes_d;
   logic [15:0]             room_words_d;
   logic [15:0]             cap_d;
   logic [3:0]              burst_d;
   logic                    accept_d;
   logic [23:0]             next_addr_d;
   logic [15:0]             next_remaining_d;

   // Bytes left before the next page boundary, expressed in words.
   assign room_bytes_d = (PAGE_W + 1)'(PAGE_BYTES) - (PAGE_W + 1)'(addr_q[PAGE_W-1:0]);
   assign room_words_d = 16'(room_bytes_d >> 1);

   always_comb begin
      cap_d   = (room_words_d < 16'(MAX_BURST)) ? room_words_d : 16'(MAX_BURST);
      burst_d = (remaining_q < cap_d) ? remaining_q[3:0] : cap_d[3:0];
   end

   // A read beat may only be taken when the one-entry output register can hold it.
   assign accept_d = (state_q == S_ISSUE) && q_valid_q && q_ready_i && (wcnt_q < burst_q) &&
                     (write_q ? s_wvalid_i : (!m_rvalid_q || m_rready_i));

   assign next_addr_d      = addr_q + {19'd0, burst_q, 1'b0};
   assign next_remaining_d = remaining_q - {12'd0, burst_q};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         remaining_q   <= '0;
         burst_q       <= '0;
         wcnt_q        <= '0;
         write_q       <= 1'b0;
         ce_q          <= '0;
         abort_pend_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
         q_valid_q     <= 1'b0;
         q_ready_ack_q <= 1'b0;
         s_wready_q    <= 1'b0;
         m_rvalid_q    <= 1'b0;
         m_rdata_q     <= '0;
      end else begin
         done_q        <= 1'b0;
         aborted_q     <= 1'b0;
         q_ready_ack_q <= 1'b0;
         s_wready_q    <= 1'b0;
         if (m_rvalid_q && m_rready_i) begin
            m_rvalid_q <= 1'b0;
         end

         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (word_count_i == 16'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     addr_q       <= base_addr_i & ~24'd1;
                     remaining_q  <= word_count_i;
                     write_q      <= write_i;
                     ce_q         <= ce_sel_i;
                     abort_pend_q <= 1'b0;
                     busy_q       <= 1'b1;
                     state_q      <= S_CALC;
                  end
               end
            end

            S_CALC: begin
               burst_q <= burst_d;
               wcnt_q  <= '0;
               if (abort_i) begin
                  abort_pend_q <= 1'b1;
                  state_q      <= S_FIN;
               end else begin
                  q_valid_q <= !write_q || s_wvalid_i;
                  state_q   <= S_ISSUE;
               end
            end

            S_ISSUE, S_ACK: begin
               if (!q_valid_q) begin
                  // Write burst still waiting for its first data word.
                  if (abort_i) begin
                     abort_pend_q <= 1'b1;
                     state_q      <= S_FIN;
                  end else if (write_q && s_wvalid_i) begin
                     q_valid_q <= 1'b1;
                  end
               end else begin
                  if (abort_i) begin
                     abort_pend_q <= 1'b1;
                  end
                  if (q_xfer_done_i) begin
                     q_valid_q   <= 1'b0;
                     addr_q      <= next_addr_d;
                     remaining_q <= next_remaining_d;
                     state_q     <= S_FIN;
                  end else if (accept_d) begin
                     q_ready_ack_q <= 1'b1;
                     wcnt_q        <= wcnt_q + 4'd1;
                     if (write_q) begin
                        s_wready_q <= 1'b1;
                     end else begin
                        m_rdata_q  <= q_rdata_i;
                        m_rvalid_q <= 1'b1;
                     end
                     state_q <= S_ACK;
                  end else begin
                     state_q <= S_ISSUE;
                  end
               end
            end

            S_FIN: begin
               if ((remaining_q == 16'd0) || abort_pend_q || abort_i) begin
                  done_q    <= 1'b1;
                  aborted_q <= abort_pend_q || abort_i;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  state_q <= S_CALC;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign aborted_o     = aborted_q;
   assign s_wready_o    = s_wready_q;
   assign m_rdata_o     = m_rdata_q;
   assign m_rvalid_o    = m_rvalid_q;
   assign q_addr_o      = addr_q;
   assign q_wdata_o     = s_wdata_i;
   assign q_wstrb_o     = write_q ? 2'b11 : 2'b00;
   assign q_valid_o     = q_valid_q;
   assign q_xfer_len_o  = burst_q;
   assign q_ce_ctrl_o   = ce_q;
   assign q_ready_ack_o = q_ready_ack_q;

endmodule

// File: tb/tb_lisa_qspi_burst_sequencer.sv
// tb/tb_lisa_qspi_burst_sequencer.sv - scoreboard bench with arbiter, source and sink models
module tb_lisa_qspi_burst_sequencer;
   localparam int CS = 2;
   localparam int MB = 8;
   localparam int PB = 256;

   logic clk = 1'b0;
   logic rst, start, write, abort;
   logic [23:0] base_addr;
   logic [15:0] word_count;
   logic [CS-1:0] ce_sel;
   logic busy, done, aborted;
   logic [15:0] s_wdata;
   logic s_wvalid, s_wready;
   logic [15:0] m_rdata;
   logic m_rvalid, m_rready;
   logic [23:0] q_addr;
   logic [15:0] q_wdata;
   logic [1:0] q_wstrb;
   logic q_valid;
   logic [3:0] q_xfer_len;
   logic [CS-1:0] q_ce_ctrl;
   logic q_ready_ack;
   logic [15:0] q_rdata;
   logic q_ready, q_xfer_done;

   lisa_qspi_burst_sequencer #(.CHIP_SELECTS(CS), .MAX_BURST(MB), .PAGE_BYTES(PB)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .write_i(write), .base_addr_i(base_addr),
      .word_count_i(word_count), .ce_sel_i(ce_sel), .abort_i(abort), .busy_o(busy),
      .done_o(done), .aborted_o(aborted), .s_wdata_i(s_wdata), .s_wvalid_i(s_wvalid),
      .s_wready_o(s_wready), .m_rdata_o(m_rdata), .m_rvalid_o(m_rvalid), .m_rready_i(m_rready),
      .q_addr_o(q_addr), .q_wdata_o(q_wdata), .q_wstrb_o(q_wstrb), .q_valid_o(q_valid),
      .q_xfer_len_o(q_xfer_len), .q_ce_ctrl_o(q_ce_ctrl), .q_ready_ack_o(q_ready_ack),
      .q_rdata_i(q_rdata), .q_ready_i(q_ready), .q_xfer_done_i(q_xfer_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] addr;
      logic [3:0]  len;
   } burst_t;

   burst_t      exp_burst[$];
   logic [15:0] exp_rd[$];
   logic [15:0] exp_wr[$];
   logic [15:0] src_q[$];
   logic        exp_done[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          done_cnt = 0;
   int          burst_seen = 0;
   logic        cur_write;
   logic [1:0]  cur_ce;
   int          wr_hold = 0;
   int          rr_hold = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic hard_fail(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s", nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference burst split: page room, MAX_BURST and remaining words, 24-bit address wrap.
   task automatic model_bursts(input logic [23:0] base, input int wc, input int limit);
      int a, rem, n, room, b;
      burst_t e;
      a = int'(base) & 32'hFFFFFE;
      rem = wc;
      n = 0;
      while (rem > 0 && n < limit) begin
         room = (PB - (a % PB)) / 2;
         b = rem;
         if (b > MB) b = MB;
         if (b > room) b = room;
         e.addr = 24'(a);
         e.len  = 4'(b);
         exp_burst.push_back(e);
         a = (a + 2 * b) % (1 << 24);
         rem -= b;
         n++;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_aborted"}, aborted, 0);
      check({tag, "_q_valid"}, q_valid, 0);
      check({tag, "_q_ready_ack"}, q_ready_ack, 0);
      check({tag, "_s_wready"}, s_wready, 0);
      check({tag, "_m_rvalid"}, m_rvalid, 0);
      check({tag, "_q_addr"}, q_addr, 0);
      check({tag, "_q_ce_ctrl"}, q_ce_ctrl, 0);
      check({tag, "_q_xfer_len"}, q_xfer_len, 0);
      check({tag, "_m_rdata"}, m_rdata, 0);
   endtask

   // mode 0: normal, 1: abort during second burst, 2: abort while computing first burst
   task automatic do_req(input logic wr, input logic [23:0] base, input int wc,
                         input logic [1:0] ce, input int mode, input int hold);
      int d0, b0, t;
      logic [15:0] w;
      cur_write = wr;
      cur_ce = ce;
      if (mode == 0) model_bursts(base, wc, 1000);
      else if (mode == 1) model_bursts(base, wc, 2);
      exp_done.push_back(mode != 0);
      if (wr) begin
         if (hold > 0) wr_hold = hold;
         for (int i = 0; i < wc; i++) begin
            w = 16'($urandom);
            src_q.push_back(w);
            exp_wr.push_back(w);
         end
      end
      d0 = done_cnt;
      b0 = burst_seen;
      start = 1'b1; write = wr; base_addr = base; word_count = 16'(wc); ce_sel = ce;
      tick();
      start = 1'b0;
      if (wc == 0) begin
         check("zero_done_next", done, 1);
         check("zero_busy", busy, 0);
      end else begin
         check("busy_after_start", busy, 1);
      end
      if (mode == 2) begin
         abort = 1'b1;
         tick();
         abort = 1'b0;
      end
      if (wr && hold > 2) begin
         for (int i = 0; i < hold - 2; i++) begin
            check("hold_q_valid", q_valid, 0);
            tick();
         end
      end
      if (mode == 1) begin
         t = 0;
         while (burst_seen < b0 + 2 && t < 1000) begin tick(); t++; end
         if (t >= 1000) hard_fail("timeout_second_burst");
         abort = 1'b1;
         tick();
         abort = 1'b0;
      end
      t = 0;
      while (done_cnt == d0 && t < 3000) begin tick(); t++; end
      if (t >= 3000) hard_fail("timeout_done");
      repeat (30) tick();
      check("one_done", done_cnt, d0 + 1);
      check("bursts_left", exp_burst.size(), 0);
      check("rdata_left", exp_rd.size(), 0);
      if (mode == 0) check("wdata_left", exp_wr.size(), 0);
      if (wc == 0 || mode == 2) check("no_burst", burst_seen, b0);
      exp_burst.delete(); exp_wr.delete(); src_q.delete(); exp_rd.delete();
   endtask

   // Arbiter client model plus burst scoreboard.
   initial begin
      int beats, dly;
      logic xfer_issued, pv;
      burst_t e;
      q_ready = 1'b0; q_xfer_done = 1'b0; q_rdata = '0;
      beats = 0; dly = 0; xfer_issued = 1'b0; pv = 1'b0;
      forever begin
         tick();
         if (rst) begin
            q_ready = 1'b0; q_xfer_done = 1'b0; beats = 0; xfer_issued = 1'b0; pv = 1'b0;
         end else begin
            if (q_xfer_done) q_xfer_done = 1'b0;
            if (q_valid && !pv) begin
               burst_seen++;
               beats = int'(q_xfer_len);
               xfer_issued = 1'b0;
               dly = $urandom_range(0, 2);
               if (cur_write) check("q_valid_rise_wvalid", s_wvalid, 1);
               if (exp_burst.size() == 0) hard_fail("unexpected_burst");
               else begin
                  e = exp_burst.pop_front();
                  check("burst_addr", q_addr, e.addr);
                  check("burst_len", q_xfer_len, e.len);
                  check("burst_wstrb", q_wstrb, cur_write ? 2'b11 : 2'b00);
                  check("burst_ce", q_ce_ctrl, cur_ce);
               end
            end
            if (!q_valid && pv) check("burst_beats_left", beats, 0);
            if (q_ready_ack) begin
               check("ack_within_burst", beats > 0, 1);
               beats--;
               if (cur_write) begin
                  check("ack_wvalid", s_wvalid, 1);
                  if (exp_wr.size() == 0) hard_fail("unexpected_write_beat");
                  else check("wdata", q_wdata, exp_wr.pop_front());
               end else begin
                  exp_rd.push_back(q_rdata);
               end
               q_ready = 1'b0;
            end else if (q_valid && beats > 0) begin
               if (!q_ready && $urandom_range(0, 3) != 0) begin
                  q_ready = 1'b1;
                  q_rdata = 16'($urandom);
               end
            end else if (q_valid && beats <= 0 && !xfer_issued) begin
               q_ready = 1'b0;
               if (dly > 0) dly--;
               else begin
                  q_xfer_done = 1'b1;
                  xfer_issued = 1'b1;
               end
            end
            pv = q_valid;
         end
      end
   end

   // Completion monitor.
   initial begin
      forever begin
         tick();
         if (!rst && done) begin
            done_cnt++;
            check("done_busy_low", busy, 0);
            if (exp_done.size() == 0) hard_fail("unexpected_done");
            else check("aborted", aborted, exp_done.pop_front());
         end
      end
   end

   // Read-data sink and scoreboard.
   initial begin
      logic lv, lr;
      m_rready = 1'b0; lv = 1'b0; lr = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            m_rready = 1'b0; lv = 1'b0; lr = 1'b0;
         end else begin
            if (q_ready_ack && !cur_write) check("read_ack_gate", lv && !lr, 0);
            if (rr_hold > 0) begin
               rr_hold--;
               m_rready = 1'b0;
            end else begin
               m_rready = ($urandom_range(0, 2) != 0);
            end
            if (m_rvalid && m_rready) begin
               if (exp_rd.size() == 0) hard_fail("unexpected_read_beat");
               else check("rdata", m_rdata, exp_rd.pop_front());
            end
            lv = m_rvalid;
            lr = m_rready;
         end
      end
   end

   // Write-data source: a word stays presented until its s_wready handshake completes.
   initial begin
      logic pop_next;
      s_wvalid = 1'b0; s_wdata = '0; pop_next = 1'b0;
      forever begin
         @(posedge clk);
         #3;
         if (rst) begin
            s_wvalid = 1'b0; pop_next = 1'b0;
         end else begin
            if (pop_next) begin
               if (src_q.size() > 0) void'(src_q.pop_front());
               pop_next = 1'b0;
               s_wvalid = 1'b0;
            end else if (s_wvalid && s_wready) begin
               pop_next = 1'b1;
            end
            if (!pop_next) begin
               if (src_q.size() == 0) s_wvalid = 1'b0;
               else if (wr_hold > 0) begin
                  wr_hold--;
                  s_wvalid = 1'b0;
               end else if (!s_wvalid && $urandom_range(0, 3) != 0) begin
                  s_wvalid = 1'b1;
                  s_wdata = src_q[0];
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Stimulus.
   initial begin
      logic wr;
      int k, wc, b0, t;
      logic [23:0] b;
      rst = 1'b1; start = 1'b0; write = 1'b0; abort = 1'b0; base_addr = '0;
      word_count = '0; ce_sel = '0; cur_write = 1'b0; cur_ce = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      #3 rst = 1'b0;
      tick(); tick();

      do_req(1'b0, 24'h000010, 5, 2'b01, 0, 0);
      do_req(1'b0, 24'h000000, 20, 2'b10, 0, 0);
      do_req(1'b1, 24'h0000FA, 6, 2'b01, 0, 0);
      do_req(1'b1, 24'h000200, 5, 2'b11, 0, 10);
      rr_hold = 20;
      do_req(1'b0, 24'h000300, 8, 2'b01, 0, 0);
      do_req(1'b0, 24'h000000, 20, 2'b01, 1, 0);
      do_req(1'b0, 24'h000500, 0, 2'b01, 0, 0);
      do_req(1'b0, 24'h000601, 7, 2'b10, 2, 0);

      for (int i = 0; i < 14; i++) begin
         wr = 1'($urandom_range(0, 1));
         k = $urandom_range(0, 2);
         if (k == 0) b = 24'($urandom);
         else if (k == 1) b = {16'($urandom), 8'hE0 | 8'($urandom_range(0, 31))};
         else b = 24'hFFFFC0 | 24'($urandom_range(0, 63));
         wc = $urandom_range(1, 40);
         do_req(wr, b, wc, 2'($urandom), 0, 0);
      end

      cur_write = 1'b0;
      cur_ce = 2'b01;
      model_bursts(24'h000080, 12, 1000);
      b0 = burst_seen;
      start = 1'b1; write = 1'b0; base_addr = 24'h000080; word_count = 16'd12; ce_sel = 2'b01;
      tick();
      start = 1'b0;
      t = 0;
      while (burst_seen == b0 && t < 200) begin tick(); t++; end
      if (t >= 200) hard_fail("timeout_reset_burst");
      repeat (3) tick();
      #3 rst = 1'b1;
      #1 check_zero("mid_reset");
      tick(); tick();
      exp_burst.delete(); exp_rd.delete(); exp_wr.delete(); src_q.delete(); exp_done.delete();
      #3 rst = 1'b0;
      tick(); tick();
      do_req(1'b0, 24'h000040, 4, 2'b01, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
